drv_seg_seq: RTL and testbench

DRV_SEG_SEQ -- requirements
Module: drv_seg_seq

---
 rtl/drv_seg_seq.sv | 100 ++++++++++
 tb/tb_drv_seg_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/drv_seg_seq.sv
// Thermometer-coded driver slice sequencer: ramps the number of enabled
// slices one at a time toward a requested target, with a programmable dwell.
module drv_seg_seq #(
   parameter  int NSEG    = 8,
   parameter  int DWELL_W = 4,
   localparam int CW      = $clog2(NSEG + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [CW-1:0]      req_code,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               force_off,
   output logic [NSEG-1:0]    seg_en,
   output logic [CW-1:0]      cur_code,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {IDLE, STEP, WAIT} state_t;

   localparam logic [CW-1:0] NSEG_C = CW'(NSEG);

   state_t             state_reg;
   logic [CW-1:0]      target_reg;
   logic [DWELL_W-1:0] dwell_reg;
   logic [DWELL_W-1:0] wait_cnt_reg;

   logic [CW-1:0]      req_target;
   logic               step_up;
   logic [CW-1:0]      step_code;

   always_comb begin
      req_target = (req_code > NSEG_C) ? NSEG_C : req_code;
      step_up    = (target_reg > cur_code);
      step_code  = step_up ? cur_code + CW'(1) : cur_code - CW'(1);
   end

   assign req_ready = (state_reg == IDLE) && !force_off;
   assign busy      = (state_reg != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         seg_en       <= '0;
         cur_code     <= '0;
         done         <= 1'b0;
         target_reg   <= '0;
         dwell_reg    <= '0;
         wait_cnt_reg <= '0;
      end else begin
         done <= 1'b0;
         if (force_off) begin
            // Emergency disable wins over any pending request or step.
            state_reg <= IDLE;
            seg_en    <= '0;
            cur_code  <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (req_valid) begin
                     target_reg <= req_target;
                     dwell_reg  <= dwell;
                     if (req_target == cur_code)
                        done <= 1'b1;
                     else
                        state_reg <= STEP;
                  end
               end
               STEP: begin
                  // Shifting keeps the enables thermometer-coded from bit 0 upward.
                  if (step_up)
                     seg_en <= {seg_en[NSEG-2:0], 1'b1};
                  else
                     seg_en <= {1'b0, seg_en[NSEG-1:1]};
                  cur_code <= step_code;
                  if (step_code == target_reg) begin
                     state_reg <= IDLE;
                     done      <= 1'b1;
                  end else if (dwell_reg == '0) begin
                     state_reg <= STEP;
                  end else begin
                     state_reg    <= WAIT;
                     wait_cnt_reg <= dwell_reg;
                  end
               end
               WAIT: begin
                  if (wait_cnt_reg == DWELL_W'(1))
                     state_reg <= STEP;
                  else
                     wait_cnt_reg <= wait_cnt_reg - DWELL_W'(1);
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_drv_seg_seq.sv
// Bench for drv_seg_seq: directed scenarios with literal expectations plus
// random traffic compared every cycle against a slice-level ramp model.
module tb_drv_seg_seq;

   localparam int NSEG    = 8;
   localparam int DWELL_W = 4;
   localparam int CW      = $clog2(NSEG + 1);

   logic               clk = 1'b0;
   logic               rst_n;
   logic               req_valid;
   logic               req_ready;
   logic [CW-1:0]      req_code;
   logic [DWELL_W-1:0] dwell;
   logic               force_off;
   logic [NSEG-1:0]    seg_en;
   logic [CW-1:0]      cur_code;
   logic               busy;
   logic               done;

   int checks = 0;
   int errors = 0;

   drv_seg_seq #(.NSEG(NSEG), .DWELL_W(DWELL_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_code(req_code), .dwell(dwell), .force_off(force_off),
      .seg_en(seg_en), .cur_code(cur_code), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: slice level plus a countdown of edges until the next step.
   int m_lvl, m_tgt, m_dw, m_cnt;
   bit m_busy, m_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lvl = 0; m_tgt = 0; m_dw = 0; m_cnt = 0; m_busy = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (force_off) begin
            m_lvl = 0; m_busy = 0;
         end else if (!m_busy) begin
            if (req_valid) begin
               m_tgt = (int'(req_code) > NSEG) ? NSEG : int'(req_code);
               m_dw  = int'(dwell);
               if (m_tgt == m_lvl) m_done = 1;
               else begin m_busy = 1; m_cnt = 0; end
            end
         end else if (m_cnt > 0) begin
            m_cnt--;
         end else begin
            m_lvl += (m_tgt > m_lvl) ? 1 : -1;
            if (m_lvl == m_tgt) begin m_busy = 0; m_done = 1; end
            else m_cnt = m_dw;
         end
      end
   end

   always @(negedge clk) begin
      longint exp_seg;
      #2;
      exp_seg = (longint'(1) << m_lvl) - 1;
      chk("seg_en", 64'(seg_en), 64'(exp_seg));
      chk("cur_code", 64'(cur_code), 64'(m_lvl));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("req_ready", 64'(req_ready), 64'(!m_busy && !force_off));
   end

   // Accepting edge is the rising edge between the two falling edges.
   task automatic do_req(input int code, input int dw);
      @(negedge clk);
      req_valid = 1'b1; req_code = CW'(code); dwell = DWELL_W'(dw);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic pulse_off();
      @(negedge clk); force_off = 1'b1;
      @(negedge clk); force_off = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_code = '0; dwell = '0; force_off = 1'b0;
      #7;
      chk("rst_seg_en", 64'(seg_en), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_done", 64'(done), 64'h0);
      @(negedge clk); rst_n = 1'b1;
      #1 chk("rst_ready", 64'(req_ready), 64'h1);

      // Ramp up 0 -> 5 with dwell 2: three-cycle step interval.
      do_req(5, 2);
      @(posedge clk); #1 chk("up_s1", 64'(seg_en), 64'h01);
      chk("up_busy", 64'(busy), 64'h1);
      repeat (3) @(posedge clk); #1 chk("up_s2", 64'(seg_en), 64'h03);
      repeat (3) @(posedge clk); #1 chk("up_s3", 64'(seg_en), 64'h07);
      repeat (3) @(posedge clk); #1 chk("up_s4", 64'(seg_en), 64'h0F);
      repeat (2) @(posedge clk); #1 chk("up_nodone", 64'(done), 64'h0);
      @(posedge clk); #1 chk("up_s5", 64'(seg_en), 64'h1F);
      chk("up_done", 64'(done), 64'h1);
      chk("up_idle", 64'(busy), 64'h0);
      @(posedge clk); #1 chk("up_done_off", 64'(done), 64'h0);

      // Ramp down 5 -> 2 with no dwell.
      do_req(2, 0);
      @(posedge clk); #1 chk("dn_s1", 64'(seg_en), 64'h0F); chk("dn_c1", 64'(cur_code), 64'd4);
      @(posedge clk); #1 chk("dn_s2", 64'(seg_en), 64'h07); chk("dn_c2", 64'(cur_code), 64'd3);
      @(posedge clk); #1 chk("dn_s3", 64'(seg_en), 64'h03); chk("dn_c3", 64'(cur_code), 64'd2);
      chk("dn_done", 64'(done), 64'h1);

      // Oversized code clamps to NSEG.
      pulse_off();
      #1 chk("off_zero", 64'(seg_en), 64'h0);
      do_req(12, 0);
      repeat (7) @(posedge clk); #1 chk("clamp_busy", 64'(busy), 64'h1);
      @(posedge clk); #1 chk("clamp_seg", 64'(seg_en), 64'hFF);
      chk("clamp_code", 64'(cur_code), 64'd8);
      chk("clamp_done", 64'(done), 64'h1);

      // No-op request and a request ignored while busy.
      do_req(3, 0);
      repeat (5) @(posedge clk); #1 chk("to3_seg", 64'(seg_en), 64'h07);
      do_req(3, 5);
      chk("noop_done", 64'(done), 64'h1);
      chk("noop_seg", 64'(seg_en), 64'h07);
      chk("noop_busy", 64'(busy), 64'h0);
      do_req(6, 1);
      req_valid = 1'b1; req_code = CW'(0); dwell = DWELL_W'(0);
      #1 chk("busy_ready", 64'(req_ready), 64'h0);
      repeat (3) @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(posedge clk); #1 chk("ign_seg", 64'(seg_en), 64'h3F);
      chk("ign_done", 64'(done), 64'h1);

      // Abort a ramp to 6 with force_off right after reaching 0x07.
      pulse_off();
      do_req(6, 0);
      repeat (3) @(posedge clk); #1 chk("abort_pre", 64'(seg_en), 64'h07);
      @(negedge clk); force_off = 1'b1;
      @(posedge clk); #1 chk("abort_seg", 64'(seg_en), 64'h00);
      chk("abort_done", 64'(done), 64'h0);
      chk("abort_busy", 64'(busy), 64'h0);
      @(negedge clk); force_off = 1'b0;
      #1 chk("abort_ready", 64'(req_ready), 64'h1);

      // Asynchronous reset mid-ramp, then a normal request.
      do_req(8, 3);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("arst_seg", 64'(seg_en), 64'h0);
      chk("arst_busy", 64'(busy), 64'h0);
      @(negedge clk); rst_n = 1'b1;
      do_req(2, 0);
      repeat (2) @(posedge clk); #1 chk("post_rst_seg", 64'(seg_en), 64'h03);
      chk("post_rst_done", 64'(done), 64'h1);

      // Random traffic, checked every cycle by the model compare.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         req_valid = ($urandom_range(0, 2) != 0);
         req_code  = CW'($urandom_range(0, (1 << CW) - 1));
         dwell     = ($urandom_range(0, 7) == 0) ? DWELL_W'($urandom_range(0, 15))
                                                 : DWELL_W'($urandom_range(0, 2));
         force_off = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #1 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
      end
      @(negedge clk);
      req_valid = 1'b0; force_off = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
